// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 64-deep byte FIFO feeding an 8N1 UART transmitter.
// Define UART_TX_PARITY_EN for an 8E1 frame with an even-parity bit after the data.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx,
    output logic              tx_busy
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int CW       = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, empty_q, overflow_q, tx_q, tx_d, busy_q;
    logic [CW-1:0]       baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          sh_q, sh_d;
    logic                push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    always_comb begin
        push     = wr_en && !full_q;
        pop      = (state_q == IDLE) && !empty_q;
        bit_end  = baud_q == CW'(BAUD_DIV - 1);
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        state_d  = state_q;
        baud_d   = (state_q == IDLE || bit_end) ? '0 : baud_q + CW'(1);
        bit_d    = bit_q;
        sh_d     = sh_q;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: if (pop) begin
                state_d = START;
                sh_d    = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                par_d   = ^mem[rd_ptr_q];
`endif
            end
            START: if (bit_end) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (bit_end) begin
                sh_d  = sh_q >> 1;
                bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // tx is registered from the current state, so the line lags the FSM by one clock
`ifdef UART_TX_PARITY_EN
        tx_d = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : state_q == PARITY ? par_q : 1'b1;
`else
        tx_d = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            baud_q     <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= count_d == (ADDR_W+1)'(DEPTH);
            empty_q    <= count_d == '0;
            overflow_q <= wr_en && full_q;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
            busy_q     <= state_q != IDLE;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: random bursts checked against a queue model and a bench-side UART receiver.
module tb_uart_tx_fifo;
    localparam int BD    = 16;
    localparam int DEPTH = 64;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = (10 + PAR) * BD;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, tx, tx_busy;
    logic [6:0] count;
    int         n_checks = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .ADDR_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int k);
        int s = k / BD;
        if (s == 0) return 1'b0;
        if (s <= 8) return d[s-1];
        if (PAR == 1 && s == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic dwait(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            tick();
            if (!reset_n) ab = 1'b1;
        end
    endtask

    // Receiver: finds the start bit, samples mid-bit, discards frames cut by reset.
    initial begin
        bit ab;
        logic [7:0] b;
        forever begin
            tick();
            if (reset_n && !tx) begin
                ab = 1'b0;
                b  = 8'h00;
                dwait(BD / 2, ab);
                if (!ab) check("rx_start", {31'd0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    dwait(BD, ab);
                    b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                dwait(BD, ab);
                if (!ab) check("rx_parity", {31'd0, tx}, {31'd0, ^b});
`endif
                dwait(BD, ab);
                if (!ab) begin
                    check("rx_stop", {31'd0, tx}, 32'd1);
                    rx_q.push_back(b);
                end
            end
        end
    end

    task automatic drain();
        int budget = (exp_q.size() + 1) * (FL + 2) + 100;
        while ((rx_q.size() < exp_q.size() || tx_busy || !empty) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("drain_timeout", 32'd1, 32'd0);
        repeat (20) tick();
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_count", {25'd0, count}, 32'd0);
        check("rx_len", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check("rx_byte", {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic frame_check(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
        check("f_empty0", {31'd0, empty}, 32'd0);
        check("f_count1", {25'd0, count}, 32'd1);
        tick();
        check("f_empty1", {31'd0, empty}, 32'd1);
        check("f_tx_pre", {31'd0, tx}, 32'd1);
        check("f_busy_pre", {31'd0, tx_busy}, 32'd0);
        for (int k = 0; k < FL; k++) begin
            tick();
            check("f_tx", {31'd0, tx}, {31'd0, exp_bit(d, k)});
            check("f_busy", {31'd0, tx_busy}, 32'd1);
        end
        tick();
        check("f_busy_end", {31'd0, tx_busy}, 32'd0);
        check("f_tx_end", {31'd0, tx}, 32'd1);
        drain();
    endtask

    // Starting idle and empty, the first byte is popped on the second write edge
    // and no further pop occurs while a burst shorter than one frame is written.
    task automatic burst(input int n);
        int peak = 0;
        int ec;
        logic [7:0] d;
        for (int i = 1; i <= n; i++) begin
            d = 8'($urandom);
            wr_en = 1'b1;
            wr_data = d;
            tick();
            if (i <= DEPTH + 1) exp_q.push_back(d);
            ec = (i == 1) ? 1 : ((i - 1) > DEPTH ? DEPTH : i - 1);
            check("b_count", {25'd0, count}, ec);
            check("b_full", {31'd0, full}, {31'd0, ec == DEPTH});
            check("b_empty", {31'd0, empty}, 32'd0);
            check("b_ovf", {31'd0, overflow}, {31'd0, i > DEPTH + 1});
            if (int'(count) > peak) peak = int'(count);
        end
        wr_en = 1'b0;
        tick();
        check("b_ovf_end", {31'd0, overflow}, 32'd0);
        check("b_peak", peak, (n - 1) > DEPTH ? DEPTH : n - 1);
        drain();
    endtask

    initial begin
        repeat (3) tick();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_count", {25'd0, count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();
        frame_check(8'h58);
        frame_check(8'h30);
        burst(54);
        burst(66);
        repeat (3) burst(40);
        repeat (3) burst($urandom_range(2, 30));
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        tick();
        wr_en = 1'b0;
        repeat (71) tick();
        check("mid_busy", {31'd0, tx_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mr_tx", {31'd0, tx}, 32'd1);
        check("mr_busy", {31'd0, tx_busy}, 32'd0);
        check("mr_empty", {31'd0, empty}, 32'd1);
        check("mr_count", {25'd0, count}, 32'd0);
        check("mr_full", {31'd0, full}, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            check("mr_tx_idle", {31'd0, tx}, 32'd1);
            check("mr_busy_idle", {31'd0, tx_busy}, 32'd0);
        end
        check("mr_rx_none", rx_q.size(), 32'd0);
        frame_check(8'hA5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
